// File: rtl/pwconv_out_writer.sv
// Output stage of the PW-conv rescale/ReLU stream. It packs four int8 results into a 32-bit word and buffers them in a small FIFO.
// The buffered words drain into the feature-map RAM through a valid/ready port, with back-pressure to the stage above and a frame-done pulse.
module pwconv_out_writer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned FRAME_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        cnt_in,
  input  logic [3:0]        pos_in,
  input  logic [7:0]        data_in0,
  input  logic [7:0]        data_in1,
  input  logic [7:0]        data_in2,
  input  logic [7:0]        data_in3,
  output logic              stall,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = $clog2(FRAME_WORDS);
  localparam int unsigned EW = ADDR_W + 32;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [FW-1:0] frame_cnt;
  logic          has_data;
  logic          push;
  logic          pop;

  // A full FIFO rejects a push even when a pop happens in the same cycle.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    count_next = count;
    entry_in   = {ADDR_W'({cnt_in, pos_in}), data_in3, data_in2, data_in1, data_in0};
    push       = in_valid && (count < CW'(FIFO_DEPTH));
    pop        = has_data && mem_wr_ready;
    count_next = count + CW'(push) - CW'(pop);
  end

  // Storage is left unreset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      has_data   <= 1'b0;
      stall      <= 1'b0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      has_data <= (count_next != '0);
      // Two beats are still in flight in the rescale pipeline when stall rises.
      stall    <= (count_next >= CW'(FIFO_DEPTH - 2));
      overflow <= overflow | (in_valid & ~push);
      frame_done <= 1'b0;
      if (pop) begin
        if (frame_cnt == FW'(FRAME_WORDS - 1)) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign mem_wr_en   = has_data;
  assign busy        = has_data;
  assign mem_wr_addr = has_data ? head[EW-1:32] : '0;
  assign mem_wr_data = has_data ? head[31:0]    : '0;

endmodule
